// File: rtl/cnn_operand_sequencer_if.sv
// Core-side bus of the CNN operand sequencer: operand load handshake,
// launch/flush control, the datapath result inputs and the held result.
interface cnn_operand_sequencer_if #(
    parameter int NUM_WORDS = 14
);
    logic                      load_valid;
    logic [31:0]               load_data;
    logic                      load_ready;
    logic                      start;
    logic [1:0]                op_sel;
    logic                      flush;
    logic                      busy;
    logic [32*NUM_WORDS-1:0]   operands;
    logic [31:0]               wino_in;
    logic [31:0]               relu_in;
    logic [31:0]               conv_in;
    logic [31:0]               result;
    logic                      result_valid;
    logic                      result_ack;

    modport master (
        output load_valid, load_data, start, op_sel, flush,
               wino_in, relu_in, conv_in, result_ack,
        input  load_ready, busy, operands, result, result_valid
    );

    modport slave (
        input  load_valid, load_data, start, op_sel, flush,
               wino_in, relu_in, conv_in, result_ack,
        output load_ready, busy, operands, result, result_valid
    );
endinterface

// File: rtl/cnn_operand_sequencer.sv
// Counter-addressed operand buffer and launch sequencer for the CNN datapath.
// Optional macro CNN_SEQ_AUTOCLR_EN: clear the buffer and refill after every ack.
module cnn_operand_sequencer #(
    parameter int NUM_WORDS   = 14,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    cnn_operand_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {FILL, READY, EXEC, HOLD} state_e;

    localparam int              TW         = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_INIT = TW'(EXEC_CYCLES - 1);
    localparam logic [3:0]      CNT_LAST   = 4'(NUM_WORDS - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [31:0]     words_q [NUM_WORDS];
    logic [31:0]     words_d [NUM_WORDS];
    logic [31:0]     result_q, result_d;
    logic            result_valid_q, result_valid_d;

    // load_ready is a state decode; rst only masks it during reset.
    assign bus.load_ready   = (state_q == FILL) && rst;
    assign bus.busy         = (state_q == EXEC);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_ops
        assign bus.operands[32*i +: 32] = words_q[i];
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        timer_d        = timer_q;
        words_d        = words_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        unique case (state_q)
            FILL: begin
                if (bus.load_valid) begin
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        if (cnt_q == i[3:0]) words_d[i] = bus.load_data;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = READY;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            READY: begin
                if (bus.start) begin
                    op_d    = bus.op_sel;
                    timer_d = TIMER_INIT;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (timer_q == '0) begin
                    unique case (op_q)
                        2'b00:   result_d = bus.wino_in;
                        2'b01:   result_d = bus.relu_in;
                        2'b10:   result_d = bus.conv_in;
                        default: result_d = 32'h0;
                    endcase
                    result_valid_d = 1'b1;
                    state_d        = HOLD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            HOLD: begin
                if (bus.result_ack) begin
                    result_valid_d = 1'b0;
`ifdef CNN_SEQ_AUTOCLR_EN
                    for (int i = 0; i < NUM_WORDS; i++) words_d[i] = '0;
                    cnt_d   = '0;
                    state_d = FILL;
`else
                    state_d = READY;
`endif
                end
            end
            default: state_d = FILL;
        endcase

        // Flush overrides any load, start or ack decided above; result itself is kept.
        if (bus.flush) begin
            for (int i = 0; i < NUM_WORDS; i++) words_d[i] = '0;
            cnt_d          = '0;
            result_valid_d = 1'b0;
            state_d        = FILL;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q        <= FILL;
            cnt_q          <= '0;
            op_q           <= '0;
            timer_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            // NOTE: the buffer is visible on the operands port, so it is reset like any other flop.
            for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            timer_q        <= timer_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            words_q        <= words_d;
        end
    end
endmodule

// File: tb/tb_cnn_operand_sequencer.sv
// Directed self-checking bench for cnn_operand_sequencer (NUM_WORDS=14, EXEC_CYCLES=2).
// Build with +define+CNN_SEQ_AUTOCLR_EN to check the auto-clear variant.
module tb_cnn_operand_sequencer;
    localparam int NW = 14;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cnn_operand_sequencer_if #(.NUM_WORDS(NW)) bus ();

    cnn_operand_sequencer #(.NUM_WORDS(NW), .EXEC_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int i);
        return bus.operands[32*i +: 32];
    endfunction

    // Streams NW words base, base+1, ...; optional idle cycle before each word.
    task automatic fill(input logic [31:0] base, input bit gaps);
        for (int i = 0; i < NW; i++) begin
            if (gaps) begin
                bus.load_valid = 1'b0;
                tick();
            end
            bus.load_valid = 1'b1;
            bus.load_data  = base + 32'(i);
            tick();
        end
        bus.load_valid = 1'b0;
    endtask

    // start pulse then two EXEC cycles; leaves the DUT in HOLD.
    task automatic launch(input logic [1:0] op);
        bus.op_sel = op;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        bus.op_sel     = 2'b00;
        bus.flush      = 1'b0;
        bus.wino_in    = 32'h5555_AAAA;
        bus.relu_in    = 32'h0000_0A05;
        bus.conv_in    = 32'hC0DE_0001;
        bus.result_ack = 1'b0;

        // Reset
        #1;
        check("ready_before_edge", {31'b0, bus.load_ready}, 32'd0);
        tick();
        tick();
        check("rst_load_ready", {31'b0, bus.load_ready}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_valid", {31'b0, bus.result_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_word0", word(0), 32'd0);
        rst = 1'b1;
        #1;
        check("fill_ready", {31'b0, bus.load_ready}, 32'd1);

        // Fill words 1..14, then one extra word offered in READY
        for (int i = 0; i < NW; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'(i + 1);
            #1;
            check($sformatf("ready_w%0d", i), {31'b0, bus.load_ready}, 32'd1);
            tick();
        end
        bus.load_data = 32'd99;
        check("ready_full", {31'b0, bus.load_ready}, 32'd0);
        tick();
        bus.load_valid = 1'b0;
        for (int i = 0; i < NW; i++) check($sformatf("word%0d", i), word(i), 32'(i + 1));

        // relu launch; a start during EXEC is ignored
        bus.op_sel = 2'b01;
        bus.start  = 1'b1;
        tick();
        check("exec1_busy", {31'b0, bus.busy}, 32'd1);
        tick();
        bus.start = 1'b0;
        check("exec2_busy", {31'b0, bus.busy}, 32'd1);
        check("exec2_valid", {31'b0, bus.result_valid}, 32'd0);
        tick();
        check("relu_busy", {31'b0, bus.busy}, 32'd0);
        check("relu_valid", {31'b0, bus.result_valid}, 32'd1);
        check("relu_result", bus.result, 32'h0000_0A05);
        bus.relu_in = 32'h1234_5678;
        tick();
        tick();
        check("hold_result", bus.result, 32'h0000_0A05);
        check("hold_valid", {31'b0, bus.result_valid}, 32'd1);
        check("hold_busy", {31'b0, bus.busy}, 32'd0);

        // Ack
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        check("ack_valid", {31'b0, bus.result_valid}, 32'd0);
`ifdef CNN_SEQ_AUTOCLR_EN
        check("ack_ready", {31'b0, bus.load_ready}, 32'd1);
        check("ack_word0", word(0), 32'd0);
        check("ack_word13", word(13), 32'd0);
        fill(32'd1, 1'b0);
`else
        check("ack_ready", {31'b0, bus.load_ready}, 32'd0);
        check("ack_word0", word(0), 32'd1);
        check("ack_word13", word(13), 32'd14);
`endif
        launch(2'b00);
        check("wino_valid", {31'b0, bus.result_valid}, 32'd1);
        check("wino_result", bus.result, 32'h5555_AAAA);
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;

        // Flush, start ignored in FILL, gapped fill of 15 offered words
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_ready", {31'b0, bus.load_ready}, 32'd1);
        check("flush_word5", word(5), 32'd0);
        bus.op_sel = 2'b11;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        check("fill_start_busy", {31'b0, bus.busy}, 32'd0);
        check("fill_start_ready", {31'b0, bus.load_ready}, 32'd1);
        fill(32'h100, 1'b1);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h10E;
        tick();
        bus.load_valid = 1'b0;
        check("gap_word0", word(0), 32'h100);
        check("gap_word13", word(13), 32'h10D);
        check("gap_ready", {31'b0, bus.load_ready}, 32'd0);

        // Reserved op captures zero
        launch(2'b11);
        check("op11_valid", {31'b0, bus.result_valid}, 32'd1);
        check("op11_result", bus.result, 32'd0);
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
`ifdef CNN_SEQ_AUTOCLR_EN
        fill(32'h200, 1'b0);
`endif

        // Flush beats start in READY
        bus.flush  = 1'b1;
        bus.start  = 1'b1;
        bus.op_sel = 2'b10;
        tick();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("fs_busy", {31'b0, bus.busy}, 32'd0);
        check("fs_ready", {31'b0, bus.load_ready}, 32'd1);
        check("fs_word0", word(0), 32'd0);
        tick();
        check("fs_busy2", {31'b0, bus.busy}, 32'd0);

        // Flush beats ack in HOLD; result retained
        fill(32'h300, 1'b0);
        launch(2'b10);
        check("conv_result", bus.result, 32'hC0DE_0001);
        bus.flush      = 1'b1;
        bus.result_ack = 1'b1;
        tick();
        bus.flush      = 1'b0;
        bus.result_ack = 1'b0;
        check("fa_valid", {31'b0, bus.result_valid}, 32'd0);
        check("fa_ready", {31'b0, bus.load_ready}, 32'd1);
        check("fa_result", bus.result, 32'hC0DE_0001);

        // Reset during EXEC
        fill(32'h400, 1'b0);
        bus.op_sel = 2'b01;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        check("mr_busy_pre", {31'b0, bus.busy}, 32'd1);
        rst = 1'b0;
        tick();
        check("mr_busy", {31'b0, bus.busy}, 32'd0);
        check("mr_valid", {31'b0, bus.result_valid}, 32'd0);
        check("mr_result", bus.result, 32'd0);
        check("mr_word0", word(0), 32'd0);
        check("mr_ready_low", {31'b0, bus.load_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("mr_ready", {31'b0, bus.load_ready}, 32'd1);
        tick();
        tick();
        check("mr_no_capture", {31'b0, bus.result_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
